// File: rtl/uart_tx_io_pkg.sv
// rtl/uart_tx_io_pkg.sv - shared addresses, status layout and FSM states for the UART transmitter
package uart_tx_io_pkg;

    localparam logic [1:0] UART_ADDR_DATA = 2'b00;
    localparam logic [1:0] UART_ADDR_STAT = 2'b01;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] pack_status(
        input logic       busy,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [3:0] count
    );
        logic [15:0] s;
        s                        = 16'h0000;
        s[STAT_BUSY]             = busy;
        s[STAT_EMPTY]            = empty;
        s[STAT_FULL]             = full;
        s[STAT_OVF]              = ovf;
        s[STAT_COUNT_LSB +: 4]   = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous byte FIFO with first-word-fall-through head
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [3:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == 4'(DEPTH));
    assign o_empty   = (r_count == 4'd0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register
module uart_tx_io
    import uart_tx_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic        uartcs,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uartwdata,
    output logic [15:0] uartrdata,
    output logic        tx
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_ovf;

    logic          w_push_req;
    logic          w_stat_rd;
    logic          w_pop;
    logic          w_tx;
    logic          w_baud_done;
    logic          w_drop;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [3:0]    w_count;
    logic          w_unused_wdata;

    assign w_unused_wdata = ^uartwdata[15:8];

    assign w_push_req  = uartwrite & uartcs & (uartaddr == UART_ADDR_DATA);
    assign w_stat_rd   = uartread & uartcs & (uartaddr == UART_ADDR_STAT);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_drop      = w_push_req & w_full & ~w_pop;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (uartwdata[7:0]),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (!w_empty)                      w_next = ST_START;
            ST_START: if (w_baud_done)                   w_next = ST_DATA;
            ST_DATA:  if (w_baud_done && r_bit == 3'd7)  w_next = ST_STOP;
            ST_STOP:  if (w_baud_done)                   w_next = ST_IDLE;
            default:                                     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx  = 1'b1;
        w_pop = 1'b0;
        unique case (r_state)
            ST_IDLE:  w_pop = ~w_empty;
            ST_START: w_tx  = 1'b0;
            ST_DATA:  w_tx  = r_shift[0];
            default:  w_tx  = 1'b1;
        endcase
    end

    assign tx = w_tx;

    // Baud counter restarts on every state change so each level lasts exactly CLKS_PER_BIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (r_state != w_next || r_state == ST_IDLE || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state == ST_DATA) begin
                if (w_baud_done) begin
                    r_bit <= r_bit + 3'd1;
                end
            end else begin
                r_bit <= 3'd0;
            end

            if (w_pop) begin
                r_shift <= w_head;
            end else if (r_state == ST_DATA && w_baud_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    // A dropped push wins over the clearing status read on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        uartrdata = 16'h0000;
        if (w_stat_rd) begin
            uartrdata = pack_status(r_state != ST_IDLE, w_empty, w_full, r_ovf, w_count);
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - randomized and directed bench for uart_tx_io against a frame-timeline model
module tb_uart_tx_io;

    localparam int C = 4;
    localparam int D = 8;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        uartwrite = 1'b0;
    logic        uartread  = 1'b0;
    logic        uartcs    = 1'b0;
    logic [1:0]  uartaddr  = 2'b00;
    logic [15:0] uartwdata = 16'h0000;
    logic [15:0] uartrdata;
    logic        tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_act = 1'b0;
    int         m_s   = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;
    int         k     = 0;

    uart_tx_io #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .uartwrite (uartwrite),
        .uartread  (uartread),
        .uartcs    (uartcs),
        .uartaddr  (uartaddr),
        .uartwdata (uartwdata),
        .uartrdata (uartrdata),
        .tx        (tx)
    );

    always #5 clock = ~clock;

    function automatic logic m_busy();
        return m_act && ((k - m_s) < 10 * C);
    endfunction

    function automatic logic [15:0] m_status();
        logic [3:0] cnt;
        cnt = 4'(mq.size());
        return {8'h00, cnt, m_ovf, (mq.size() == D), (mq.size() == 0), m_busy()};
    endfunction

    function automatic logic m_tx();
        int off;
        if (!m_busy()) return 1'b1;
        off = (k - m_s) / C;
        if (off == 0) return 1'b0;
        if (off == 9) return 1'b1;
        return m_cur[off - 1];
    endfunction

    function automatic logic [15:0] m_rdata();
        if (uartread && uartcs && uartaddr == 2'b01) return m_status();
        return 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pop, preq, acc, srd;
        if (reset) begin
            mq.delete();
            m_act = 1'b0;
            m_ovf = 1'b0;
            k++;
            return;
        end
        pop  = !m_busy() && (mq.size() > 0);
        preq = uartwrite && uartcs && (uartaddr == 2'b00);
        srd  = uartread && uartcs && (uartaddr == 2'b01);
        acc  = preq && ((mq.size() < D) || pop);
        if (pop) begin
            m_cur = mq.pop_front();
            m_s   = k + 1;
            m_act = 1'b1;
        end
        if (acc) mq.push_back(uartwdata[7:0]);
        if (preq && !acc) m_ovf = 1'b1;
        else if (srd) m_ovf = 1'b0;
        k++;
    endtask

    task automatic step();
        logic [15:0] e_rd;
        logic        e_tx;
        e_rd = m_rdata();
        e_tx = m_tx();
        #4;
        check("tx", {15'b0, tx}, {15'b0, e_tx});
        check("rdata", uartrdata, e_rd);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic cs,
                       input logic [1:0] a, input logic [15:0] d);
        uartwrite = w;
        uartread  = r;
        uartcs    = cs;
        uartaddr  = a;
        uartwdata = d;
    endtask

    initial begin
        bit found;
        int r;

        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus(0, 1, 1, 2'b01, 16'h0);
        #1;
        check("rst_status", uartrdata, 16'h0002);
        check("rst_tx", {15'b0, tx}, 16'h0001);

        repeat (50) step();
        check("idle_status", uartrdata, 16'h0002);

        bus(1, 0, 1, 2'b00, 16'h00A5);
        step();
        bus(0, 1, 1, 2'b01, 16'h0);
        step();
        check("a5_start_fall", {15'b0, tx}, 16'h0000);
        repeat (45) step();

        for (int i = 1; i <= 3; i++) begin
            bus(1, 0, 1, 2'b00, 16'(i));
            step();
        end
        bus(0, 1, 1, 2'b01, 16'h0);
        repeat (130) step();

        for (int i = 0; i < 10; i++) begin
            bus(1, 0, 1, 2'b00, 16'(8'h10 + i));
            step();
        end
        bus(0, 1, 1, 2'b01, 16'h0);
        #1;
        check("ovf_first_read", uartrdata, 16'h008D);
        step();
        check("ovf_second_read", {15'b0, uartrdata[3]}, 16'h0000);
        repeat (9 * (10 * C + 1) + 10) step();

        bus(1, 0, 1, 2'b00, 16'h00FF);
        step();
        bus(1, 0, 1, 2'b00, 16'h0011); step();
        bus(1, 0, 1, 2'b00, 16'h0022); step();
        bus(1, 0, 1, 2'b00, 16'h0033); step();
        bus(0, 0, 0, 2'b00, 16'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_act && (k - m_s) == 4 * C + 1) found = 1'b1;
            else step();
        end
        check("reach_bit3", {15'b0, found}, 16'h0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus(0, 1, 1, 2'b01, 16'h0);
        #1;
        check("rst_mid_status", uartrdata, 16'h0002);
        check("rst_mid_tx", {15'b0, tx}, 16'h0001);
        repeat (60) step();

        for (int a = 0; a < 4; a++) begin
            if (a != 1) begin
                bus(0, 1, 1, 2'(a), 16'h0);
                #1;
                check("rd_other_addr", uartrdata, 16'h0000);
                step();
            end
        end
        bus(0, 1, 0, 2'b01, 16'h0);
        #1;
        check("rd_no_cs", uartrdata, 16'h0000);
        step();
        bus(1, 0, 1, 2'b01, 16'h0055); step();
        bus(1, 0, 1, 2'b10, 16'h0056); step();
        bus(1, 0, 1, 2'b11, 16'h0057); step();
        bus(1, 0, 0, 2'b00, 16'h0058); step();
        bus(0, 1, 1, 2'b01, 16'h0);
        #1;
        check("ignored_writes", uartrdata, 16'h0002);
        step();

        repeat (800) begin
            r = $urandom_range(0, 99);
            bus(r < 10, 1'($urandom_range(0, 1)), r < 95,
                (r < 6) ? 2'b00 : 2'($urandom_range(0, 3)), 16'($urandom));
            step();
        end

        bus(0, 1, 1, 2'b01, 16'h0);
        repeat (400) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
